// File: rtl/rs_br_pkg.sv
// Shared widths and the branch payload type for the branch reservation station.
// Width macros fall back to RV32 defaults when constants.vh has not set them.
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 6
`endif
`ifndef RS_BR_ENTRY_NUM
`define RS_BR_ENTRY_NUM 4
`endif

package rs_br_pkg;
    localparam int DATA_W = `RV32_DATA_WIDTH;
    localparam int PC_W   = `RV32_PC_WIDTH;
    localparam int ALU_W  = `ALU_OP_SEL;

    typedef struct packed {
        logic             is_jal;
        logic             is_jalr;
        logic [ALU_W-1:0] alu_op;
        logic [PC_W-1:0]  pc;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]  pred_jmpaddr;
    } br_pld_t;
endpackage

// File: rtl/rs_br_entry.sv
// One reservation-station slot: payload storage plus dual-port CDB wakeup (CDB0 wins).
// With RS_BR_CDB_BYPASS_EN the operand outputs also reflect a same-cycle CDB hit.
module rs_br_entry
    import rs_br_pkg::*;
#(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_wr,
    input  logic                 i_clr,
    input  br_pld_t              i_pld,
    input  logic [TAG_WIDTH-1:0] i_rob_tag,
    input  logic [DATA_W-1:0]    i_rs1,
    input  logic [DATA_W-1:0]    i_rs2,
    input  logic                 i_rs1_rdy,
    input  logic                 i_rs2_rdy,
    input  logic [TAG_WIDTH-1:0] i_rs1_tag,
    input  logic [TAG_WIDTH-1:0] i_rs2_tag,
    input  logic                 i_cdb0_vld,
    input  logic [TAG_WIDTH-1:0] i_cdb0_tag,
    input  logic [DATA_W-1:0]    i_cdb0_data,
    input  logic                 i_cdb1_vld,
    input  logic [TAG_WIDTH-1:0] i_cdb1_tag,
    input  logic [DATA_W-1:0]    i_cdb1_data,
    output logic                 o_vld,
    output br_pld_t              o_pld,
    output logic [TAG_WIDTH-1:0] o_rob_tag,
    output logic [DATA_W-1:0]    o_rs1,
    output logic [DATA_W-1:0]    o_rs2,
    output logic                 o_rs1_rdy,
    output logic                 o_rs2_rdy
);
    logic                 r_vld;
    br_pld_t              r_pld;
    logic [TAG_WIDTH-1:0] r_rob_tag;
    logic [DATA_W-1:0]    r_rs1, r_rs2;
    logic                 r_rs1_rdy, r_rs2_rdy;
    logic [TAG_WIDTH-1:0] r_rs1_tag, r_rs2_tag;

    logic [DATA_W-1:0]    w_dp_rs1, w_dp_rs2, w_wk_rs1, w_wk_rs2;
    logic                 w_dp_rs1_rdy, w_dp_rs2_rdy, w_wk_rs1_rdy, w_wk_rs2_rdy;

    // Dispatch-time capture: an operand whose producer broadcasts this cycle enters ready.
    always_comb begin
        w_dp_rs1_rdy = i_rs1_rdy;
        w_dp_rs1     = i_rs1;
        w_dp_rs2_rdy = i_rs2_rdy;
        w_dp_rs2     = i_rs2;
        if (!i_rs1_rdy) begin
            if (i_cdb0_vld && (i_cdb0_tag == i_rs1_tag)) begin
                w_dp_rs1_rdy = 1'b1;
                w_dp_rs1     = i_cdb0_data;
            end else if (i_cdb1_vld && (i_cdb1_tag == i_rs1_tag)) begin
                w_dp_rs1_rdy = 1'b1;
                w_dp_rs1     = i_cdb1_data;
            end
        end
        if (!i_rs2_rdy) begin
            if (i_cdb0_vld && (i_cdb0_tag == i_rs2_tag)) begin
                w_dp_rs2_rdy = 1'b1;
                w_dp_rs2     = i_cdb0_data;
            end else if (i_cdb1_vld && (i_cdb1_tag == i_rs2_tag)) begin
                w_dp_rs2_rdy = 1'b1;
                w_dp_rs2     = i_cdb1_data;
            end
        end
    end

    always_comb begin
        w_wk_rs1_rdy = r_rs1_rdy;
        w_wk_rs1     = r_rs1;
        w_wk_rs2_rdy = r_rs2_rdy;
        w_wk_rs2     = r_rs2;
        if (!r_rs1_rdy) begin
            if (i_cdb0_vld && (i_cdb0_tag == r_rs1_tag)) begin
                w_wk_rs1_rdy = 1'b1;
                w_wk_rs1     = i_cdb0_data;
            end else if (i_cdb1_vld && (i_cdb1_tag == r_rs1_tag)) begin
                w_wk_rs1_rdy = 1'b1;
                w_wk_rs1     = i_cdb1_data;
            end
        end
        if (!r_rs2_rdy) begin
            if (i_cdb0_vld && (i_cdb0_tag == r_rs2_tag)) begin
                w_wk_rs2_rdy = 1'b1;
                w_wk_rs2     = i_cdb0_data;
            end else if (i_cdb1_vld && (i_cdb1_tag == r_rs2_tag)) begin
                w_wk_rs2_rdy = 1'b1;
                w_wk_rs2     = i_cdb1_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= 1'b0;
            r_pld     <= '0;
            r_rob_tag <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1_rdy <= 1'b0;
            r_rs2_rdy <= 1'b0;
            r_rs1_tag <= '0;
            r_rs2_tag <= '0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_wr) begin
            r_vld     <= 1'b1;
            r_pld     <= i_pld;
            r_rob_tag <= i_rob_tag;
            r_rs1     <= w_dp_rs1;
            r_rs2     <= w_dp_rs2;
            r_rs1_rdy <= w_dp_rs1_rdy;
            r_rs2_rdy <= w_dp_rs2_rdy;
            r_rs1_tag <= i_rs1_tag;
            r_rs2_tag <= i_rs2_tag;
        end else begin
            if (i_clr) begin
                r_vld <= 1'b0;
            end
            if (r_vld) begin
                r_rs1     <= w_wk_rs1;
                r_rs2     <= w_wk_rs2;
                r_rs1_rdy <= w_wk_rs1_rdy;
                r_rs2_rdy <= w_wk_rs2_rdy;
            end
        end
    end

    assign o_vld     = r_vld;
    assign o_pld     = r_pld;
    assign o_rob_tag = r_rob_tag;
`ifdef RS_BR_CDB_BYPASS_EN
    assign o_rs1     = w_wk_rs1;
    assign o_rs2     = w_wk_rs2;
    assign o_rs1_rdy = w_wk_rs1_rdy;
    assign o_rs2_rdy = w_wk_rs2_rdy;
`else
    assign o_rs1     = r_rs1;
    assign o_rs2     = r_rs2;
    assign o_rs1_rdy = r_rs1_rdy;
    assign o_rs2_rdy = r_rs2_rdy;
`endif
endmodule

// File: rtl/rs_br.sv
// Branch reservation station: in-order circular buffer, issue from head once both operands ready.
// RS_BR_CDB_BYPASS_EN lets a same-cycle CDB broadcast make the head issuable.
module rs_br
    import rs_br_pkg::*;
#(
    parameter int ENTRY_NUM = `RS_BR_ENTRY_NUM,
    parameter int TAG_WIDTH = `ROB_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_dp_vld,
    input  logic                 i_dp_is_jal,
    input  logic                 i_dp_is_jalr,
    input  logic [ALU_W-1:0]     i_dp_alu_op,
    input  logic [PC_W-1:0]      i_dp_pc,
    input  logic [PC_W-1:0]      i_dp_pred_jmpaddr,
    input  logic [DATA_W-1:0]    i_dp_imm,
    input  logic [DATA_W-1:0]    i_dp_rs1,
    input  logic [DATA_W-1:0]    i_dp_rs2,
    input  logic                 i_dp_rs1_rdy,
    input  logic                 i_dp_rs2_rdy,
    input  logic [TAG_WIDTH-1:0] i_dp_rs1_tag,
    input  logic [TAG_WIDTH-1:0] i_dp_rs2_tag,
    input  logic [TAG_WIDTH-1:0] i_dp_rob_tag,
    input  logic                 i_cdb0_vld,
    input  logic [TAG_WIDTH-1:0] i_cdb0_tag,
    input  logic [DATA_W-1:0]    i_cdb0_data,
    input  logic                 i_cdb1_vld,
    input  logic [TAG_WIDTH-1:0] i_cdb1_tag,
    input  logic [DATA_W-1:0]    i_cdb1_data,
    input  logic                 i_issue_rdy,
    output logic                 o_issue_vld,
    output logic                 o_is_jal,
    output logic                 o_is_jalr,
    output logic [ALU_W-1:0]     o_alu_op,
    output logic [PC_W-1:0]      o_pc,
    output logic [DATA_W-1:0]    o_imm,
    output logic [PC_W-1:0]      o_pred_jmpaddr,
    output logic [DATA_W-1:0]    o_rs1,
    output logic [DATA_W-1:0]    o_rs2,
    output logic [TAG_WIDTH-1:0] o_rob_tag,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam int              PTR_W    = $clog2(ENTRY_NUM);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(ENTRY_NUM);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_cnt;

    logic                 w_dp, w_iss;
    br_pld_t              w_dp_pld;
    logic                 w_e_vld     [ENTRY_NUM];
    br_pld_t              w_e_pld     [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] w_e_rob     [ENTRY_NUM];
    logic [DATA_W-1:0]    w_e_rs1     [ENTRY_NUM];
    logic [DATA_W-1:0]    w_e_rs2     [ENTRY_NUM];
    logic                 w_e_rs1_rdy [ENTRY_NUM];
    logic                 w_e_rs2_rdy [ENTRY_NUM];
    br_pld_t              w_head_pld;

    assign o_full  = (r_cnt == CNT_FULL);
    assign o_empty = (r_cnt == '0);

    // Full is judged on registered count only, so a same-cycle issue never admits a dispatch.
    assign w_dp  = i_dp_vld && !o_full && !i_flush;
    assign o_issue_vld = !i_flush && w_e_vld[r_head] && w_e_rs1_rdy[r_head] && w_e_rs2_rdy[r_head];
    assign w_iss = o_issue_vld && i_issue_rdy;

    always_comb begin
        w_dp_pld              = '0;
        w_dp_pld.is_jal       = i_dp_is_jal;
        w_dp_pld.is_jalr      = i_dp_is_jalr;
        w_dp_pld.alu_op       = i_dp_alu_op;
        w_dp_pld.pc           = i_dp_pc;
        w_dp_pld.imm          = i_dp_imm;
        w_dp_pld.pred_jmpaddr = i_dp_pred_jmpaddr;
    end

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
        rs_br_entry #(.TAG_WIDTH(TAG_WIDTH)) u_ent (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (i_flush),
            .i_wr        (w_dp && (r_tail == PTR_W'(g))),
            .i_clr       (w_iss && (r_head == PTR_W'(g))),
            .i_pld       (w_dp_pld),
            .i_rob_tag   (i_dp_rob_tag),
            .i_rs1       (i_dp_rs1),
            .i_rs2       (i_dp_rs2),
            .i_rs1_rdy   (i_dp_rs1_rdy),
            .i_rs2_rdy   (i_dp_rs2_rdy),
            .i_rs1_tag   (i_dp_rs1_tag),
            .i_rs2_tag   (i_dp_rs2_tag),
            .i_cdb0_vld  (i_cdb0_vld),
            .i_cdb0_tag  (i_cdb0_tag),
            .i_cdb0_data (i_cdb0_data),
            .i_cdb1_vld  (i_cdb1_vld),
            .i_cdb1_tag  (i_cdb1_tag),
            .i_cdb1_data (i_cdb1_data),
            .o_vld       (w_e_vld[g]),
            .o_pld       (w_e_pld[g]),
            .o_rob_tag   (w_e_rob[g]),
            .o_rs1       (w_e_rs1[g]),
            .o_rs2       (w_e_rs2[g]),
            .o_rs1_rdy   (w_e_rs1_rdy[g]),
            .o_rs2_rdy   (w_e_rs2_rdy[g])
        );
    end

    assign w_head_pld     = w_e_pld[r_head];
    assign o_is_jal       = w_head_pld.is_jal;
    assign o_is_jalr      = w_head_pld.is_jalr;
    assign o_alu_op       = w_head_pld.alu_op;
    assign o_pc           = w_head_pld.pc;
    assign o_imm          = w_head_pld.imm;
    assign o_pred_jmpaddr = w_head_pld.pred_jmpaddr;
    assign o_rs1          = w_e_rs1[r_head];
    assign o_rs2          = w_e_rs2[r_head];
    assign o_rob_tag      = w_e_rob[r_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_dp) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_iss) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_dp && !w_iss) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else if (!w_dp && w_iss) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_rs_br.sv
// Bench for rs_br: queue-based reference model, issue scoreboard checked by a separate monitor.
module tb_rs_br;
    import rs_br_pkg::*;

    localparam int TW = 6;
    localparam int NE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              i_flush, i_dp_vld, i_dp_is_jal, i_dp_is_jalr;
    logic [ALU_W-1:0]  i_dp_alu_op;
    logic [PC_W-1:0]   i_dp_pc, i_dp_pred_jmpaddr;
    logic [DATA_W-1:0] i_dp_imm, i_dp_rs1, i_dp_rs2;
    logic              i_dp_rs1_rdy, i_dp_rs2_rdy;
    logic [TW-1:0]     i_dp_rs1_tag, i_dp_rs2_tag, i_dp_rob_tag;
    logic              i_cdb0_vld, i_cdb1_vld;
    logic [TW-1:0]     i_cdb0_tag, i_cdb1_tag;
    logic [DATA_W-1:0] i_cdb0_data, i_cdb1_data;
    logic              i_issue_rdy;
    logic              o_issue_vld, o_is_jal, o_is_jalr, o_full, o_empty;
    logic [ALU_W-1:0]  o_alu_op;
    logic [PC_W-1:0]   o_pc, o_pred_jmpaddr;
    logic [DATA_W-1:0] o_imm, o_rs1, o_rs2;
    logic [TW-1:0]     o_rob_tag;

    rs_br #(.ENTRY_NUM(NE), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_dp_vld(i_dp_vld), .i_dp_is_jal(i_dp_is_jal), .i_dp_is_jalr(i_dp_is_jalr),
        .i_dp_alu_op(i_dp_alu_op), .i_dp_pc(i_dp_pc), .i_dp_pred_jmpaddr(i_dp_pred_jmpaddr),
        .i_dp_imm(i_dp_imm), .i_dp_rs1(i_dp_rs1), .i_dp_rs2(i_dp_rs2),
        .i_dp_rs1_rdy(i_dp_rs1_rdy), .i_dp_rs2_rdy(i_dp_rs2_rdy),
        .i_dp_rs1_tag(i_dp_rs1_tag), .i_dp_rs2_tag(i_dp_rs2_tag), .i_dp_rob_tag(i_dp_rob_tag),
        .i_cdb0_vld(i_cdb0_vld), .i_cdb0_tag(i_cdb0_tag), .i_cdb0_data(i_cdb0_data),
        .i_cdb1_vld(i_cdb1_vld), .i_cdb1_tag(i_cdb1_tag), .i_cdb1_data(i_cdb1_data),
        .i_issue_rdy(i_issue_rdy), .o_issue_vld(o_issue_vld),
        .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr), .o_alu_op(o_alu_op), .o_pc(o_pc),
        .o_imm(o_imm), .o_pred_jmpaddr(o_pred_jmpaddr), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_rob_tag(o_rob_tag), .o_full(o_full), .o_empty(o_empty)
    );

    typedef struct {
        logic              jal, jalr;
        logic [ALU_W-1:0]  alu;
        logic [PC_W-1:0]   pc, pred;
        logic [DATA_W-1:0] imm, v1, v2;
        bit                r1, r2;
        logic [TW-1:0]     t1, t2, rob;
    } ent_t;

    ent_t mq[$];     // model contents of the station, oldest first
    ent_t exp_q[$];  // issues the model predicts, awaiting the monitor
    int checks = 0;
    int failures = 0;
    logic [TW-1:0] rob_ctr = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Operand wakeup rule: a not-ready operand takes the data of a matching CDB, CDB0 first.
    function automatic ent_t wake(ent_t e);
        if (!e.r1) begin
            if (i_cdb0_vld && i_cdb0_tag == e.t1) begin e.r1 = 1; e.v1 = i_cdb0_data; end
            else if (i_cdb1_vld && i_cdb1_tag == e.t1) begin e.r1 = 1; e.v1 = i_cdb1_data; end
        end
        if (!e.r2) begin
            if (i_cdb0_vld && i_cdb0_tag == e.t2) begin e.r2 = 1; e.v2 = i_cdb0_data; end
            else if (i_cdb1_vld && i_cdb1_tag == e.t2) begin e.r2 = 1; e.v2 = i_cdb1_data; end
        end
        return e;
    endfunction

    task automatic idle();
        i_flush = 0; i_dp_vld = 0; i_dp_is_jal = 0; i_dp_is_jalr = 0; i_dp_alu_op = '0;
        i_dp_pc = '0; i_dp_pred_jmpaddr = '0; i_dp_imm = '0; i_dp_rs1 = '0; i_dp_rs2 = '0;
        i_dp_rs1_rdy = 0; i_dp_rs2_rdy = 0; i_dp_rs1_tag = '0; i_dp_rs2_tag = '0; i_dp_rob_tag = '0;
        i_cdb0_vld = 0; i_cdb0_tag = '0; i_cdb0_data = '0;
        i_cdb1_vld = 0; i_cdb1_tag = '0; i_cdb1_data = '0;
    endtask

    task automatic dp(logic jal, logic jalr, logic [PC_W-1:0] pc,
                      logic [DATA_W-1:0] v1, bit r1, logic [TW-1:0] t1,
                      logic [DATA_W-1:0] v2, bit r2, logic [TW-1:0] t2);
        i_dp_vld = 1; i_dp_is_jal = jal; i_dp_is_jalr = jalr;
        i_dp_alu_op = ALU_W'($urandom); i_dp_pc = pc;
        i_dp_pred_jmpaddr = $urandom; i_dp_imm = $urandom;
        i_dp_rs1 = v1; i_dp_rs1_rdy = r1; i_dp_rs1_tag = t1;
        i_dp_rs2 = v2; i_dp_rs2_rdy = r2; i_dp_rs2_tag = t2;
        i_dp_rob_tag = rob_ctr;
        rob_ctr = rob_ctr + 1'b1;
    endtask

    task automatic cdb(int port, logic [TW-1:0] tag, logic [DATA_W-1:0] data);
        if (port == 0) begin i_cdb0_vld = 1; i_cdb0_tag = tag; i_cdb0_data = data; end
        else           begin i_cdb1_vld = 1; i_cdb1_tag = tag; i_cdb1_data = data; end
    endtask

    // Predict this cycle's outputs from the model, then advance the model past the clock edge.
    task automatic model_step();
        ent_t h, e;
        bit can_iss;
        int n0;
        n0 = mq.size();
        can_iss = 0;
        if (!i_flush && n0 > 0) begin
            h = mq[0];
`ifdef RS_BR_CDB_BYPASS_EN
            h = wake(h);
`endif
            can_iss = h.r1 && h.r2;
        end
        chk("issue_vld", o_issue_vld, can_iss);
        chk("full", o_full, n0 == NE);
        chk("empty", o_empty, n0 == 0);
        if (i_flush) begin
            mq.delete();
            return;
        end
        if (can_iss && i_issue_rdy) begin
            exp_q.push_back(h);
            void'(mq.pop_front());
        end
        foreach (mq[k]) mq[k] = wake(mq[k]);
        if (i_dp_vld && n0 != NE) begin
            e.jal = i_dp_is_jal; e.jalr = i_dp_is_jalr; e.alu = i_dp_alu_op;
            e.pc = i_dp_pc; e.pred = i_dp_pred_jmpaddr; e.imm = i_dp_imm;
            e.v1 = i_dp_rs1; e.r1 = i_dp_rs1_rdy; e.t1 = i_dp_rs1_tag;
            e.v2 = i_dp_rs2; e.r2 = i_dp_rs2_rdy; e.t2 = i_dp_rs2_tag;
            e.rob = i_dp_rob_tag;
            mq.push_back(wake(e));
        end
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst && o_issue_vld && i_issue_rdy) begin
            chk("exp_q_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("iss_jal", o_is_jal, e.jal);
                chk("iss_jalr", o_is_jalr, e.jalr);
                chk("iss_alu", o_alu_op, e.alu);
                chk("iss_pc", o_pc, e.pc);
                chk("iss_imm", o_imm, e.imm);
                chk("iss_pred", o_pred_jmpaddr, e.pred);
                chk("iss_rs1", o_rs1, e.v1);
                chk("iss_rs2", o_rs2, e.v2);
                chk("iss_rob", o_rob_tag, e.rob);
            end
        end
    end

    initial begin
        idle();
        i_issue_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_vld", o_issue_vld, 0);
        chk("rst_full", o_full, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_pc", o_pc, 0);
        chk("rst_rs1", o_rs1, 0);
        chk("rst_rob", o_rob_tag, 0);
        rst = 0;

        // jal with ready operands issues the cycle after dispatch
        i_issue_rdy = 1;
        dp(1, 0, 32'h100, 32'h1, 1, 0, 32'h2, 1, 0); tick();
        tick();
        tick();

        // beq waiting on tag 5, woken by CDB0
        dp(0, 0, 32'h200, 0, 0, 5, 32'h9, 1, 0); tick();
        tick();
        cdb(0, 5, 32'h7); tick();
        tick(); tick();

        // fill, drop a fifth dispatch, then free one entry
        i_issue_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            dp(0, 0, 32'h300 + 4 * i, $urandom, 1, 0, $urandom, 1, 0); tick();
        end
        i_issue_rdy = 1; tick();
        for (int i = 0; i < 10; i++) begin
            dp(0, 1, 32'h400 + 4 * i, $urandom, 1, 0, $urandom, 1, 0); tick();
        end
        repeat (5) tick();

        // stuck head blocks a younger ready entry until CDB1 tag 3
        dp(0, 0, 32'h500, 0, 0, 3, 32'h1, 1, 0); tick();
        dp(1, 0, 32'h504, 32'h2, 1, 0, 32'h3, 1, 0); tick();
        tick();
        cdb(1, 3, 32'h33); tick();
        repeat (3) tick();

        // same-cycle capture at dispatch
        i_issue_rdy = 0;
        dp(0, 0, 32'h600, 0, 0, 9, 32'h4, 1, 0); cdb(0, 9, 32'hAB); tick();
        tick();
        i_issue_rdy = 1; tick();
        tick();

        // flush with three valid entries and a concurrent dispatch
        i_issue_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            dp(0, 0, 32'h700 + 4 * i, $urandom, 1, 0, $urandom, 1, 0); tick();
        end
        i_flush = 1; dp(0, 0, 32'h7F0, 0, 1, 0, 0, 1, 0); tick();
        i_issue_rdy = 1; tick();
        tick();

        // randomized traffic with an asynchronous reset midway
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1;
                #1;
                chk("arst_issue_vld", o_issue_vld, 0);
                chk("arst_empty", o_empty, 1);
                chk("arst_full", o_full, 0);
                chk("arst_pc", o_pc, 0);
                chk("arst_rs2", o_rs2, 0);
                mq.delete();
                @(posedge clk);
                #1;
                rst = 0;
            end
            if ($urandom_range(0, 2) != 0)
                dp($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                   $urandom, $urandom_range(0, 2) != 0, TW'($urandom_range(1, 7)),
                   $urandom, $urandom_range(0, 2) != 0, TW'($urandom_range(1, 7)));
            if ($urandom_range(0, 9) < 4) cdb(0, TW'($urandom_range(1, 7)), $urandom);
            if ($urandom_range(0, 9) < 4) cdb(1, TW'($urandom_range(1, 7)), $urandom);
            i_flush = ($urandom_range(0, 49) == 0);
            i_issue_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end

        // drain: broadcast every tag in use, then let the head run out
        i_issue_rdy = 1;
        for (int t = 1; t <= 7; t++) begin
            cdb(0, TW'(t), $urandom); tick();
        end
        repeat (6) tick();
        chk("final_empty", o_empty, 1);
        chk("final_exp_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_br.md
# rs_br

Branch reservation station: buffers dispatched branch/jump ops until both source operands are valid, then issues them in program order to the branch execution unit. It sits between dispatch/rename and the branch unit, which resolves the jump condition, target and prediction success. It snoops two common-data-bus (CDB) ports to wake up waiting operands. A flush clears it on misprediction recovery.

## Interface
- ENTRY_NUM, 4: number of entries; power of two, at least 2.
- TAG_WIDTH, 6: ROB/physical tag width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous squash of all entries.
- i_dp_vld  in  1  dispatch request; ignored when o_full=1 or i_flush=1.
- i_dp_is_jal, i_dp_is_jalr  in  1 each  op kind.
- i_dp_alu_op  in  `ALU_OP_SEL  compare op for conditional branches.
- i_dp_pc, i_dp_pred_jmpaddr  in  `RV32_PC_WIDTH each  PC and predicted next PC.
- i_dp_imm  in  `RV32_DATA_WIDTH  immediate.
- i_dp_rs1, i_dp_rs2  in  `RV32_DATA_WIDTH each  operand values, valid when the matching rdy is 1.
- i_dp_rs1_rdy, i_dp_rs2_rdy  in  1 each  operand already available.
- i_dp_rs1_tag, i_dp_rs2_tag  in  TAG_WIDTH each  producer tags when not ready.
- i_dp_rob_tag  in  TAG_WIDTH  ROB tag of the branch.
- i_cdb0_vld, i_cdb1_vld  in  1 each  broadcast valid.
- i_cdb0_tag, i_cdb1_tag  in  TAG_WIDTH each  broadcast tag.
- i_cdb0_data, i_cdb1_data  in  `RV32_DATA_WIDTH each  broadcast value.
- i_issue_rdy  in  1  branch unit accepts this cycle.
- o_issue_vld  out  1  head entry issuable.
- o_is_jal, o_is_jalr, o_alu_op, o_pc, o_imm, o_pred_jmpaddr, o_rs1, o_rs2, o_rob_tag  out  widths as dispatch fields  head entry payload.
- o_full, o_empty  out  1 each  occupancy flags.

## Operation
- Circular buffer: head pointer, tail pointer (log2(ENTRY_NUM) bits each, natural wrap) and count (log2(ENTRY_NUM)+1 bits). Per entry: valid, payload, rs1/rs2 rdy, tag and value.
- Dispatch: when i_dp_vld=1 and o_full=0, write the entry at tail, then tail+1 and count+1.
- Wakeup: each valid entry with a not-ready operand compares its tag against each valid CDB port. On match, it captures the data and sets rdy. If both ports match the same tag, CDB0 wins.
- Same-cycle capture at dispatch: if a not-ready dispatched operand's tag matches a valid CDB, it is written ready with the CDB data.
- Issue is in order and from the head only. o_issue_vld = head valid, rs1 rdy and rs2 rdy. Payload outputs are combinational from the head entry.
- On o_issue_vld && i_issue_rdy, the head is freed: head+1, count-1.
- Simultaneous dispatch and issue leave count unchanged. When full, dispatch is blocked even if issue frees an entry in the same cycle, because o_full depends on registered count only.
- i_flush=1 clears all valid bits and resets head, tail and count to 0. It has priority over dispatch, issue and wakeup. o_issue_vld is forced to 0 in the flush cycle.
- Reset values: all valid=0, head=tail=count=0, o_issue_vld=0, o_full=0, o_empty=1, payload outputs 0.
- A stuck head (operands not ready) blocks younger ready entries. This is intended.

## Timing
- Dispatch to earliest issue: 1 cycle, with operands ready at dispatch.
- CDB broadcast to issue of a waiting head: 1 cycle without bypass; same cycle with the configuration macro defined.
- o_full and o_empty are registered-state-derived, so there is no combinational path from i_dp_vld or i_issue_rdy.
- Asserting rst mid-operation immediately clears all state, independent of clk.

## Configuration
- RS_BR_CDB_BYPASS_EN defined:
  - A head operand that is not ready but matches a valid CDB tag this cycle counts as ready.
  - o_rs1 and o_rs2 take the CDB data, with CDB0 priority.
  - The entry still captures the value if it is not issued.
- Undefined: o_issue_vld and the operand outputs use registered entry state only.

## Structure
- ENTRY_NUM-derived pointer widths are local. `RV32_DATA_WIDTH, `RV32_PC_WIDTH and `ALU_OP_SEL come from constants.vh. Add `ROB_TAG_WIDTH and `RS_BR_ENTRY_NUM there as defaults.
- One sub-module, rs_br_entry, holds one entry's storage and dual-port CDB wakeup compare. It is instantiated ENTRY_NUM times.

## Test plan
- Dispatch a jal at PC=0x100 with both rdy=1, i_issue_rdy=1 → next cycle o_issue_vld=1, o_pc=0x100; following cycle o_empty=1.
- Dispatch a beq with rs1 tag 5 not ready; CDB0 tag 5 data 0x7 at cycle N → o_issue_vld=1 at N+1 (at N with RS_BR_CDB_BYPASS_EN), o_rs1=0x7.
- Fill 4 entries with i_issue_rdy=0 → o_full=1; a 5th dispatch is dropped. Then issue one → o_full=0 next cycle, and pointer wrap is verified over 10 dispatch/issue pairs.
- Head waits on tag 3 while entry 1 is ready → o_issue_vld=0 until CDB1 tag 3 arrives; issue order is head then entry 1.
- Dispatch with tag 9 while CDB0 broadcasts tag 9 data 0xAB in the same cycle → entry is captured ready with 0xAB.
- i_flush with 3 valid entries plus a concurrent dispatch → next cycle o_empty=1, o_issue_vld=0. Also assert rst asynchronously mid-stream → outputs are at reset values before the next edge.
